// File: rtl/toggle_activity_counter.sv
// toggle_activity_counter
// Samples N_SIG monitored nets once per clock over a programmable window,
// counts per-signal toggles (saturating) and accumulates a weighted
// switching-energy figure. The result is offered with a valid/ready handshake.
module toggle_activity_counter #(
  parameter int N_SIG = 2,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int WT_W  = 4,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [N_SIG*WT_W-1:0]    cap_w,
  input  logic [N_SIG-1:0]         sig_in,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_SIG*CNT_W-1:0]   tog_cnt,
  output logic [ACC_W-1:0]         energy
);

  // Per-sample weighted sum needs room for N_SIG maximum weights.
  localparam int SUM_W = WT_W + $clog2(N_SIG + 1);
  // One spare bit above the larger operand exposes accumulator overflow.
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [N_SIG-1:0]        prev;
  logic [WIN_W-1:0]        remaining;
  logic [N_SIG*WT_W-1:0]   weights;
  logic                    accept_start;
  logic                    last_sample;
  logic [N_SIG-1:0]        toggles;
  logic [SUM_W-1:0]        step_energy;
  logic [EXT_W-1:0]        energy_sum;
  logic [ACC_W-1:0]        energy_next;
  logic [N_SIG*CNT_W-1:0]  tog_next;

  assign accept_start = (state == IDLE) && start && (win_len != {WIN_W{1'b0}});
  assign last_sample  = (remaining == {{(WIN_W-1){1'b0}}, 1'b1});

  // Toggle detection against the previous sample.
  always_comb begin
    toggles = sig_in ^ prev;
  end

  // Weighted switching energy of this sample, summed across all signals.
  always_comb begin
    step_energy = {SUM_W{1'b0}};
    for (int i = 0; i < N_SIG; i++) begin
      if (toggles[i]) begin
        step_energy = step_energy + SUM_W'(weights[i*WT_W +: WT_W]);
      end else begin
        step_energy = step_energy;
      end
    end
  end

  // Full-width accumulate, then clamp at the accumulator maximum.
  always_comb begin
    energy_sum = EXT_W'(energy) + EXT_W'(step_energy);
    if (energy_sum[EXT_W-1:ACC_W] != '0) begin
      energy_next = {ACC_W{1'b1}};
    end else begin
      energy_next = energy_sum[ACC_W-1:0];
    end
  end

  // Saturating per-signal toggle counter increment.
  always_comb begin
    tog_next = tog_cnt;
    for (int i = 0; i < N_SIG; i++) begin
      if (toggles[i] && (tog_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        tog_next[i*CNT_W +: CNT_W] = tog_cnt[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        tog_next[i*CNT_W +: CNT_W] = tog_cnt[i*CNT_W +: CNT_W];
      end
    end
  end

  // Next-state logic for the measurement window FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_start) state_next = COUNT;
        else              state_next = IDLE;
      end
      COUNT: begin
        if (last_sample) state_next = HOLD;
        else             state_next = COUNT;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
        else           state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Window datapath: capture on start, accumulate in COUNT, hold in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      remaining <= '0;
      weights   <= '0;
      tog_cnt   <= '0;
      energy    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_start) begin
            remaining <= win_len;
            weights   <= cap_w;
            prev      <= sig_in;
            tog_cnt   <= '0;
            energy    <= '0;
          end
        end
        COUNT: begin
          tog_cnt   <= tog_next;
          energy    <= energy_next;
          prev      <= sig_in;
          remaining <= remaining - {{(WIN_W-1){1'b0}}, 1'b1};
          if (last_sample) out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Scoreboard bench for toggle_activity_counter: stimulus pushes expected
// results into queues, monitors pop and compare when out_valid rises.
module tb_toggle_activity_counter;

  typedef struct {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] e;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // default-parameter instance
  logic        start = 1'b0;
  logic [15:0] win_len = 16'd0;
  logic [7:0]  cap_w = 8'd0;
  logic [1:0]  sig_in = 2'b00;
  logic        busy, out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] tog_cnt;
  logic [23:0] energy;

  // narrow instance for saturation
  logic        start2 = 1'b0;
  logic [15:0] win_len2 = 16'd0;
  logic [7:0]  cap_w2 = 8'd0;
  logic [1:0]  sig_in2 = 2'b00;
  logic        busy2, out_valid2;
  logic        out_ready2 = 1'b1;
  logic [7:0]  tog_cnt2;
  logic [5:0]  energy2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic pv1 = 1'b0;
  logic pv2 = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  toggle_activity_counter dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .cap_w(cap_w),
    .sig_in(sig_in), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .tog_cnt(tog_cnt), .energy(energy)
  );

  toggle_activity_counter #(.CNT_W(4), .ACC_W(6)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .win_len(win_len2), .cap_w(cap_w2),
    .sig_in(sig_in2), .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready2),
    .tog_cnt(tog_cnt2), .energy(energy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor for the default instance
  always @(negedge clk) begin
    if (!rst && out_valid && !pv1) begin
      if (q1.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q1.pop_front();
        chk("tog0", {16'd0, tog_cnt[15:0]}, x.t0);
        chk("tog1", {16'd0, tog_cnt[31:16]}, x.t1);
        chk("energy", {8'd0, energy}, x.e);
        chk("latency", cyc, x.due);
      end
    end
    pv1 <= out_valid;
  end

  // monitor for the saturation instance
  always @(negedge clk) begin
    if (!rst && out_valid2 && !pv2) begin
      if (q2.size() == 0) begin
        chk("unexpected_valid2", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q2.pop_front();
        chk("sat_tog0", {28'd0, tog_cnt2[3:0]}, x.t0);
        chk("sat_tog1", {28'd0, tog_cnt2[7:4]}, x.t1);
        chk("sat_energy", {26'd0, energy2}, x.e);
        chk("sat_latency", cyc, x.due);
      end
    end
    pv2 <= out_valid2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a start with the given window; called #1 after an edge
  task automatic do_start(input logic [15:0] wl, input logic [7:0] cw, input logic [1:0] base);
    start = 1'b1; win_len = wl; cap_w = cw; sig_in = base;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_tog", tog_cnt, 32'd0);
    chk("rst_energy", {8'd0, energy}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // complementary toggle: w1=1, w0=3, 8 samples -> {8,8}, 32
    e = '{t0: 32'd8, t1: 32'd8, e: 32'd32, due: cyc + 1 + 8};
    q1.push_back(e);
    do_start(16'd8, {4'd1, 4'd3}, 2'b01);
    for (int j = 0; j < 8; j++) begin
      sig_in = ~sig_in;
      tick();
    end
    tick(); tick();
    chk("comp_busy_after", {31'd0, busy}, 32'd0);

    // static input, 5 samples -> {0,0}, 0
    e = '{t0: 32'd0, t1: 32'd0, e: 32'd0, due: cyc + 1 + 5};
    q1.push_back(e);
    do_start(16'd5, {4'd7, 4'd9}, 2'b01);
    for (int j = 0; j < 5; j++) tick();
    tick(); tick();

    // win_len 0 is ignored
    do_start(16'd0, {4'd1, 4'd1}, 2'b00);
    chk("wl0_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("wl0_busy2", {31'd0, busy}, 32'd0);

    // win_len 1, one toggle on bit0, w0=3 -> {0,1}, 3
    e = '{t0: 32'd1, t1: 32'd0, e: 32'd3, due: cyc + 1 + 1};
    q1.push_back(e);
    do_start(16'd1, {4'd5, 4'd3}, 2'b00);
    sig_in = 2'b01;
    tick();
    tick(); tick();

    // backpressure with ignored start: w1=2, w0=5, one toggle each -> {1,1}, 7
    out_ready = 1'b0;
    e = '{t0: 32'd1, t1: 32'd1, e: 32'd7, due: cyc + 1 + 3};
    q1.push_back(e);
    do_start(16'd3, {4'd2, 4'd5}, 2'b00);
    sig_in = 2'b11;
    for (int j = 0; j < 3; j++) tick();
    for (int j = 0; j < 5; j++) begin
      start = 1'b1; win_len = 16'd4; sig_in = ~sig_in;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_tog", tog_cnt, {16'd1, 16'd1});
      chk("bp_energy", {8'd0, energy}, 32'd7);
      tick();
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_hold_tog", tog_cnt, {16'd1, 16'd1});
    tick();
    chk("bp_no_restart", {31'd0, busy}, 32'd0);

    // saturation on the narrow instance: 20 samples, weights 3/1 -> {15,15}, 63
    e = '{t0: 32'd15, t1: 32'd15, e: 32'd63, due: cyc + 1 + 20};
    q2.push_back(e);
    start2 = 1'b1; win_len2 = 16'd20; cap_w2 = {4'd1, 4'd3}; sig_in2 = 2'b00;
    tick();
    start2 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      sig_in2 = ~sig_in2;
      tick();
    end
    tick(); tick();

    // reset mid-window: no result may ever appear
    do_start(16'd10, {4'd1, 4'd3}, 2'b00);
    for (int j = 0; j < 4; j++) begin
      sig_in = ~sig_in;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_tog", tog_cnt, 32'd0);
    chk("mid_rst_energy", {8'd0, energy}, 32'd0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      sig_in = ~sig_in;
      tick();
    end
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // drain: every expected result must have been presented
    for (int j = 0; j < 20 && (q1.size() != 0 || q2.size() != 0); j++) tick();
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
